// File: rtl/gb_audio_i2s.sv
// GB audio to I2S bridge: 128-clk boxcar average of the APU mix,
// DC removal, and mono 16-bit I2S serialisation at clk/128.
module gb_audio_i2s #(
    parameter logic [15:0] DC_OFFSET = 16'h4000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] audio_in,
    input  logic        enable,
    output logic        sample_strobe,
    output logic [15:0] sample_out,
    output logic        i2s_bclk,
    output logic        i2s_lrclk,
    output logic        i2s_sdata
);

    logic [6:0]  r_cyc;
    logic [22:0] r_acc;
    logic        r_mute;
    logic [15:0] r_sample;
    logic        r_strobe;
    logic        r_sdata;

    logic [6:0]  w_cyc_nxt;
    logic        w_frame_end;
    logic [15:0] w_term;
    logic [22:0] w_sum;
    logic [15:0] w_avg;
    logic [4:0]  w_slot;
    logic [3:0]  w_idx;
    logic        w_bit;

    assign w_cyc_nxt   = r_cyc + 7'd1;
    assign w_frame_end = (r_cyc == 7'd127);
    assign w_term      = enable ? audio_in : 16'h0000;
    assign w_sum       = r_acc + {7'd0, w_term};
    assign w_avg       = 16'(w_sum >> 7);

    // Slot k in 1..16 carries bit 16-k, k in 17..31 carries bit 32-k;
    // both reduce to (-k) mod 16. Slot 0 re-sends the old word's LSB,
    // which is still in r_sample on the latch edge.
    assign w_slot = w_cyc_nxt[6:2];
    assign w_idx  = 4'd0 - w_slot[3:0];
    assign w_bit  = (w_slot == 5'd0) ? r_sample[0] : r_sample[w_idx];

    // Free-running frame counter, wraps 127 -> 0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_cyc <= 7'd0;
        else       r_cyc <= w_cyc_nxt;
    end

    // Accumulate one frame, latch average minus DC at frame end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc    <= 23'd0;
            r_mute   <= 1'b0;
            r_sample <= 16'h0000;
        end else if (w_frame_end) begin
            r_acc    <= 23'd0;
            r_mute   <= 1'b0;
            r_sample <= (r_mute || !enable) ? 16'h0000
                                            : w_avg - DC_OFFSET;
        end else if (!enable) begin
            r_acc  <= 23'd0;
            r_mute <= 1'b1;
        end else begin
            r_acc <= w_sum;
        end
    end

    // One-cycle strobe in the cycle after a latch (cyc = 0)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_strobe <= 1'b0;
        else       r_strobe <= w_frame_end;
    end

    // Serial data updated only at slot starts (BCLK falling edge)
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                       r_sdata <= 1'b0;
        else if (w_cyc_nxt[1:0] == 2'b00) r_sdata <= w_bit;
    end

    assign sample_strobe = r_strobe;
    assign sample_out    = r_sample;
    assign i2s_bclk      = r_cyc[1];
    assign i2s_lrclk     = r_cyc[6];
    assign i2s_sdata     = r_sdata;

endmodule

// File: tb/tb_gb_audio_i2s.sv
// Directed bench for gb_audio_i2s: two instances (DC 0x4000 and 0),
// expected samples queued per frame and compared on the next frame.
module tb_gb_audio_i2s;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] audio_in = 16'h0000;
    logic        enable = 1'b1;

    logic        strobe_a, bclk_a, lrclk_a, sdata_a;
    logic        strobe_b, bclk_b, lrclk_b, sdata_b;
    logic [15:0] out_a, out_b;

    int checks = 0;
    int failures = 0;

    logic [15:0] qa[$];
    logic [15:0] qb[$];
    logic [15:0] cur_a, cur_b;
    logic        lsb_a, lsb_b;
    bit          first;

    always #5 clk = ~clk;

    gb_audio_i2s u_dut_a (
        .clk(clk), .reset(reset), .audio_in(audio_in), .enable(enable),
        .sample_strobe(strobe_a), .sample_out(out_a),
        .i2s_bclk(bclk_a), .i2s_lrclk(lrclk_a), .i2s_sdata(sdata_a)
    );

    gb_audio_i2s #(.DC_OFFSET(16'h0000)) u_dut_b (
        .clk(clk), .reset(reset), .audio_in(audio_in), .enable(enable),
        .sample_strobe(strobe_b), .sample_out(out_b),
        .i2s_bclk(bclk_b), .i2s_lrclk(lrclk_b), .i2s_sdata(sdata_b)
    );

    task automatic chk16(input string tag, input logic [15:0] obs,
                         input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp,
                        input int c);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, c, obs, exp);
        end
    endtask

    // I2S bit expected at frame cycle c for word s, previous LSB p
    function automatic logic exp_bit(input logic [15:0] s, input logic p,
                                     input int c);
        int k;
        k = c / 4;
        if (k == 0)       return p;
        else if (k <= 16) return s[16 - k];
        else              return s[32 - k];
    endfunction

    task automatic zero_outputs(input string tag);
        chk16({tag, "_out_a"}, out_a, 16'h0000);
        chk16({tag, "_out_b"}, out_b, 16'h0000);
        chk1({tag, "_strobe_a"}, strobe_a, 1'b0, 0);
        chk1({tag, "_bclk_a"}, bclk_a, 1'b0, 0);
        chk1({tag, "_lrclk_a"}, lrclk_a, 1'b0, 0);
        chk1({tag, "_sdata_a"}, sdata_a, 1'b0, 0);
        chk1({tag, "_sdata_b"}, sdata_b, 1'b0, 0);
    endtask

    task automatic restart();
        first = 1'b1;
        cur_a = 16'h0000;
        cur_b = 16'h0000;
        lsb_a = 1'b0;
        lsb_b = 1'b0;
        qa.delete();
        qb.delete();
    endtask

    // One frame: entered at a negedge with DUT cyc = 0.
    // mode 0 const v, 1 alternate 0/0x100, 2 const v with gap 40..60, 3 random
    task automatic run_frame(input int mode, input logic [15:0] v,
                             input int stop_at);
        logic [22:0] sum;
        logic        mute;
        logic [15:0] d;
        logic        en;
        logic [6:0]  cc;
        sum  = 23'd0;
        mute = 1'b0;
        for (int c = 0; c < 128; c++) begin
            if (c == stop_at) return;
            cc = 7'(c);
            if (c == 0 && !first) begin
                lsb_a = cur_a[0];
                lsb_b = cur_b[0];
                if (qa.size() == 0 || qb.size() == 0) begin
                    chk1("queue_empty", 1'b1, 1'b0, c);
                end else begin
                    cur_a = qa.pop_front();
                    cur_b = qb.pop_front();
                end
            end
            if (c == 0) begin
                chk16("sample_a", out_a, cur_a);
                chk16("sample_b", out_b, cur_b);
            end
            chk1("strobe_a", strobe_a, (c == 0) && !first, c);
            chk1("strobe_b", strobe_b, (c == 0) && !first, c);
            chk1("bclk", bclk_a, cc[1], c);
            chk1("lrclk", lrclk_a, cc[6], c);
            chk1("sdata_a", sdata_a, exp_bit(cur_a, lsb_a, c), c);
            chk1("sdata_b", sdata_b, exp_bit(cur_b, lsb_b, c), c);
            en = 1'b1;
            d  = v;
            case (mode)
                1: d = cc[0] ? 16'h0100 : 16'h0000;
                2: en = !(c >= 40 && c <= 60);
                3: d = 16'($urandom);
                default: d = v;
            endcase
            audio_in = d;
            enable   = en;
            if (en) sum = sum + {7'd0, d};
            else    mute = 1'b1;
            @(negedge clk);
        end
        first = 1'b0;
        qa.push_back(mute ? 16'h0000 : 16'(sum >> 7) - 16'h4000);
        qb.push_back(mute ? 16'h0000 : 16'(sum >> 7));
    endtask

    initial begin
        restart();
        @(negedge clk);
        zero_outputs("por");
        @(negedge clk);
        reset = 1'b0;

        run_frame(0, 16'h4000, -1);
        run_frame(0, 16'h7FC0, -1);
        run_frame(1, 16'h0000, -1);
        run_frame(2, 16'h7FC0, -1);
        run_frame(3, 16'h0000, -1);
        run_frame(0, 16'h7FF0, -1);
        run_frame(0, 16'h4000, -1);
        run_frame(0, 16'h1234, 50);

        reset = 1'b1;
        #1;
        zero_outputs("async_rst");
        @(negedge clk);
        reset = 1'b0;
        restart();

        run_frame(0, 16'h7FC0, -1);
        run_frame(0, 16'h0000, -1);
        run_frame(3, 16'h0000, -1);
        run_frame(0, 16'h0000, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
